// File: rtl/uart_tx_frame.sv
// Ready/valid UART transmitter: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit; PARITY_ODD then selects odd parity.
module uart_tx_frame #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam int IDX_W    = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_frame: BAUD_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_bit;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_cnt;
  logic                 bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      s_ready  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // Every state change happens on bit_end, so the wrap doubles as the per-transition clear.
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (s_valid) begin
            shreg    <= s_data;
            baud_cnt <= '0;
            state    <= START;
            tx       <= 1'b0;
            s_ready  <= 1'b0;
            busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit  <= (^s_data) ^ (PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              tx       <= par_bit;
`else
              state    <= STOP;
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              state   <= IDLE;
              tx      <= 1'b1;
              s_ready <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8N1 instance and a 7-data/2-stop odd-parity instance against a frame-level model.
module tb_uart_tx_frame;

  localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sv = 2'b00;
  logic [7:0] sd0 = '0;
  logic [6:0] sd1 = '0;
  logic [1:0] tx_w, rdy_w, busy_w, done_w;

  int passed = 0;
  int total = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8),
                  .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst_n(rst_n), .s_data(sd0), .s_valid(sv[0]), .s_ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(7),
                  .STOP_BITS(2), .PARITY_ODD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .s_data(sd1), .s_valid(sv[1]), .s_ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int db_of(int i);   return (i == 0) ? 8 : 7; endfunction
  function automatic int sb_of(int i);   return (i == 0) ? 1 : 2; endfunction
  function automatic int odd_of(int i);  return (i == 0) ? 0 : 1; endfunction
  function automatic int flen(int i);    return 1 + db_of(i) + P + sb_of(i); endfunction
  function automatic int sd_of(int i);   return (i == 0) ? int'(sd0) : int'(sd1); endfunction

  // Line level of frame bit k for a character: start, data LSB first, parity, stop bits.
  function automatic int fbit(int data, int db, int odd, int k);
    int m;
    m = data & ((1 << db) - 1);
    if (k == 0) return 0;
    if (k <= db) return (m >> (k - 1)) & 1;
    if (P == 1 && k == db + 1) return ($countones(m) % 2) ^ odd;
    return 1;
  endfunction

  bit act [2];
  bit edone [2];
  int st [2];
  int ch [2];
  int done_cnt [2];
  int last_done [2];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      edone[i] = 1'b0;
      if (!rst_n) act[i] = 1'b0;
      else if (act[i] && (cyc - st[i]) == flen(i) * BD) begin
        act[i] = 1'b0;
        edone[i] = 1'b1;
      end else if (!act[i] && sv[i]) begin
        act[i] = 1'b1;
        st[i] = cyc;
        ch[i] = sd_of(i);
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("tx%0d", i), int'(tx_w[i]),
          act[i] ? fbit(ch[i], db_of(i), odd_of(i), (cyc - st[i]) / BD) : 1);
      chk($sformatf("busy%0d", i), int'(busy_w[i]), int'(act[i]));
      chk($sformatf("ready%0d", i), int'(rdy_w[i]), int'(!act[i]));
      chk($sformatf("done%0d", i), int'(done_w[i]), int'(edone[i]));
      if (done_w[i]) begin
        done_cnt[i]++;
        last_done[i] = cyc;
      end
    end
  end

  task automatic send(int i, int data, output int c);
    @(negedge clk);
    if (i == 0) sd0 = 8'(data); else sd1 = 7'(data);
    sv[i] = 1'b1;
    @(posedge clk);
    #1 c = cyc;
    @(negedge clk);
    sv[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int target);
    int k;
    k = 0;
    while (done_cnt[i] < target && k < 400) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (done_cnt[i] < target) chk($sformatf("done_timeout%0d", i), done_cnt[i], target);
  endtask

  initial begin
    int c0, c1, dc;
    logic [10:0] ea;

    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx_w[0]), 1);
    chk("rst_ready", int'(rdy_w[0]), 1);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_done", int'(done_w[0]), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_done", done_cnt[0] + done_cnt[1], 0);

    // 0xA5 on the 8-bit instance, sampled mid-bit against literal levels
    ea = (P == 1) ? {1'b1, 1'b0, 8'hA5, 1'b0} : {1'b1, 1'b1, 8'hA5, 1'b0};
    send(0, 'hA5, c0);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("a5_bit%0d", k), int'(tx_w[0]), int'(ea[k]));
      if (k < 9) repeat (10) @(negedge clk);
    end
    wait_done(0, 1);
    chk("a5_len", last_done[0] - c0, (P == 1) ? 110 : 100);
    chk("a5_done_cnt", done_cnt[0], 1);

    // 0x07: parity bit position (even on u_a, odd on u_b)
    send(0, 'h07, c0);
    repeat (94) @(negedge clk);
    chk("par_even", int'(tx_w[0]), 1);
    wait_done(0, 2);
    chk("par_len_a", last_done[0] - c0, (P == 1) ? 110 : 100);
    send(1, 'h07, c1);
    repeat (84) @(negedge clk);
    chk("par_odd", int'(tx_w[1]), (P == 1) ? 0 : 1);
    wait_done(1, 1);
    chk("par_len_b", last_done[1] - c1, (P == 1) ? 110 : 100);

    // back-to-back with s_valid held
    @(negedge clk);
    sd0 = 8'h55;
    sv[0] = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    sd0 = 8'hAA;
    wait_done(0, 3);
    @(posedge clk);
    #1;
    chk("b2b_gap", cyc - c0, (P == 1) ? 111 : 101);
    chk("b2b_busy", int'(busy_w[0]), 1);
    chk("b2b_start", int'(tx_w[0]), 0);
    @(negedge clk);
    sv[0] = 1'b0;
    wait_done(0, 4);
    chk("b2b_done_cnt", done_cnt[0], 4);

    // 7-bit/2-stop frame with a stray request during data bit 2
    send(1, 'h3C, c1);
    repeat (34) @(negedge clk);
    sd1 = 7'h7F;
    sv[1] = 1'b1;
    @(negedge clk);
    sv[1] = 1'b0;
    sd1 = '0;
    wait_done(1, 2);
    chk("b_len", last_done[1] - c1, (P == 1) ? 110 : 100);
    repeat (30) @(negedge clk);
    chk("b_no_resend", int'(busy_w[1]), 0);
    chk("b_done_cnt", done_cnt[1], 2);

    // reset during data bit 3 of 0xFF, then a clean 0x12
    send(0, 'hFF, c0);
    repeat (44) @(negedge clk);
    dc = done_cnt[0];
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(tx_w[0]), 1);
    chk("mid_rst_busy", int'(busy_w[0]), 0);
    chk("mid_rst_ready", int'(rdy_w[0]), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    chk("mid_rst_no_done", done_cnt[0], dc);
    chk("mid_rst_ready_after", int'(rdy_w[0]), 1);
    send(0, $urandom_range(1, 0) == 0 ? 'h12 : 'h12, c0);
    wait_done(0, dc + 1);
    chk("post_rst_len", last_done[0] - c0, (P == 1) ? 110 : 100);

    // randomized characters on both instances
    for (int n = 0; n < 6; n++) begin
      send(0, int'($urandom_range(255, 0)), c0);
      send(1, int'($urandom_range(127, 0)), c1);
      wait_done(0, dc + 2 + n);
      wait_done(1, 3 + n);
      repeat (int'($urandom_range(5, 0))) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
